// File: rtl/zle_pkg.sv
// Shared definitions for the ZLE encoder/decoder pair: token layout defaults
// and the decoder state encodings.
package zle_pkg;

    localparam int DW_DEF = 16;
    localparam int CW_DEF = 4;
    localparam int MAXRUN = (1 << CW_DEF) - 1;

    // Token layout: flag sits just above the data field, the count in the low bits.
    localparam int FLAG_BIT = DW_DEF;
    localparam int LIT_LSB  = 0;
    localparam int CNT_LSB  = 0;

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_LIT   = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_ILL   = 2'd3;

endpackage

// File: rtl/zle_dec_fsm.sv
// Decoder control: state register, next-state selection and the stream
// handshake on both sides. Token contents arrive as pre-decoded flags.
module zle_dec_fsm
    import zle_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       i_v,
    input  logic       o_b,
    input  logic       i_tok_is_run,
    input  logic       i_cnt_eq_0,
    input  logic       i_rem_eq_1,
    output logic       i_b,
    output logic       o_v,
    output logic       o_load,
    output logic       o_dec,
    output logic [1:0] stateo
);

    logic [1:0] r_state;
    logic [1:0] w_next;
    logic [1:0] w_target;

    // Where a freshly accepted token sends us; a zero-count run emits nothing.
    always_comb begin
        w_target = S_LIT;
        if (i_tok_is_run) begin
            w_target = i_cnt_eq_0 ? S_FETCH : S_RUN;
        end
    end

    always_comb begin
        w_next = r_state;
        i_b    = 1'b1;
        o_v    = 1'b0;
        o_load = 1'b0;
        o_dec  = 1'b0;
        case (r_state)
            S_FETCH: begin
                i_b = 1'b0;
                if (i_v) begin
                    o_load = 1'b1;
                    w_next = w_target;
                end
            end
            S_LIT: begin
                o_v = 1'b1;
                i_b = o_b;
                if (!o_b) begin
                    o_load = i_v;
                    w_next = i_v ? w_target : S_FETCH;
                end
            end
            S_RUN: begin
                o_v = 1'b1;
                if (!i_rem_eq_1) begin
                    i_b   = 1'b1;
                    o_dec = !o_b;
                end else begin
                    // Last zero of the run: overlap its transfer with the next token.
                    i_b = o_b;
                    if (!o_b) begin
                        o_load = i_v;
                        w_next = i_v ? w_target : S_FETCH;
                    end
                end
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    assign stateo = r_state;

endmodule

// File: rtl/zle_dec.sv
// Zero run-length decoder: expands literal / zero-run tokens into a flat
// word stream at one word per cycle.
module zle_dec
    import zle_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_v,
    input  logic [DW:0]   i_d,
    output logic          i_b,
    output logic          o_v,
    output logic [DW-1:0] o_d,
    input  logic          o_b,
    output logic          err,
    output logic [1:0]    stateo
);

    logic [DW-1:0] r_tok;
    logic [CW-1:0] r_rem;
    logic          r_err;

    logic          w_tok_is_run;
    logic [CW-1:0] w_cnt;
    logic          w_cnt_eq_0;
    logic          w_rem_eq_1;
    logic          w_load;
    logic          w_dec;

    assign w_tok_is_run = i_d[DW];
    assign w_cnt        = i_d[CW-1:0];
    assign w_cnt_eq_0   = (w_cnt == '0);
    assign w_rem_eq_1   = (r_rem == CW'(1));

    zle_dec_fsm u_fsm (
        .clock        (clock),
        .reset        (reset),
        .i_v          (i_v),
        .o_b          (o_b),
        .i_tok_is_run (w_tok_is_run),
        .i_cnt_eq_0   (w_cnt_eq_0),
        .i_rem_eq_1   (w_rem_eq_1),
        .i_b          (i_b),
        .o_v          (o_v),
        .o_load       (w_load),
        .o_dec        (w_dec),
        .stateo       (stateo)
    );

    // Load and decrement never coincide: decrement only happens while rem > 1.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_tok <= '0;
            r_rem <= '0;
            r_err <= 1'b0;
        end else if (w_load) begin
            if (!w_tok_is_run) begin
                r_tok <= i_d[DW-1:0];
            end else if (w_cnt_eq_0) begin
                r_err <= 1'b1;
            end else begin
                r_rem <= w_cnt;
            end
        end else if (w_dec) begin
            r_rem <= r_rem - CW'(1);
        end
    end

    assign o_d = (stateo == S_LIT) ? r_tok : '0;
    assign err = r_err;

endmodule

// File: tb/tb_zle_dec.sv
// Bench for zle_dec: directed scenarios plus random traffic, all checked
// against a queue of expected output words built from accepted tokens.
module tb_zle_dec;

    localparam int DW = 16;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          i_v   = 1'b0;
    logic [DW:0]   i_d   = '0;
    logic          o_b   = 1'b0;
    logic          i_b;
    logic          o_v;
    logic [DW-1:0] o_d;
    logic          err;
    logic [1:0]    stateo;

    zle_dec #(.DW(DW), .CW(CW)) dut (
        .clock  (clock),
        .reset  (reset),
        .i_v    (i_v),
        .i_d    (i_d),
        .i_b    (i_b),
        .o_v    (o_v),
        .o_d    (o_d),
        .o_b    (o_b),
        .err    (err),
        .stateo (stateo)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [DW-1:0] w;
        logic          run;
    } word_t;

    int    n_vec = 0;
    int    n_bad = 0;
    word_t q[$];
    bit    m_err = 1'b0;
    bit    acc   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DW:0] lit(input logic [DW-1:0] v);
        return {1'b0, v};
    endfunction

    function automatic logic [DW:0] run(input int c);
        logic [DW-CW-1:0] junk;
        logic [CW-1:0]    cnt;
        junk = (DW-CW)'($urandom);
        cnt  = CW'(c);
        return {1'b1, junk, cnt};
    endfunction

    // One clock: check outputs against the pending-word queue, then apply transfers.
    task automatic cycle();
        bit    exp_ib;
        bit    in_x;
        bit    out_x;
        int    exp_st;
        @(negedge clock);
        exp_ib = (q.size() > 1) || (q.size() == 1 && o_b);
        exp_st = (q.size() == 0) ? 0 : (q[0].run ? 2 : 1);
        check("o_v", 32'(o_v), 32'(q.size() != 0));
        check("i_b", 32'(i_b), 32'(exp_ib));
        check("err", 32'(err), 32'(m_err));
        check("stateo", 32'(stateo), 32'(exp_st));
        in_x  = i_v && !exp_ib;
        out_x = (q.size() != 0) && !o_b;
        if (out_x) begin
            check("o_d", 32'(o_d), 32'(q[0].w));
            void'(q.pop_front());
        end
        if (in_x) begin
            if (!i_d[DW]) begin
                q.push_back(word_t'{w: i_d[DW-1:0], run: 1'b0});
            end else if (i_d[CW-1:0] == '0) begin
                m_err = 1'b1;
            end else begin
                repeat (int'(i_d[CW-1:0])) q.push_back(word_t'{w: '0, run: 1'b1});
            end
        end
        acc = in_x;
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [DW:0] tok);
        i_v = 1'b1;
        i_d = tok;
        for (int k = 0; k < 60; k++) begin
            cycle();
            if (acc) break;
        end
        check("send_accepted", 32'(acc), 32'd1);
        i_v = 1'b0;
        i_d = (DW+1)'($urandom);
    endtask

    task automatic drain(input bit toggle);
        o_b = toggle;
        for (int k = 0; k < 200; k++) begin
            if (q.size() == 0) break;
            cycle();
            if (toggle) o_b = ~o_b;
        end
        check("drain_empty", 32'(q.size()), 32'd0);
        o_b = 1'b0;
    endtask

    initial begin
        #1;
        check("rst_o_v", 32'(o_v), 32'd0);
        check("rst_i_b", 32'(i_b), 32'd0);
        check("rst_o_d", 32'(o_d), 32'd0);
        check("rst_stateo", 32'(stateo), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Back-to-back literals.
        send(lit(16'd5));
        send(lit(16'd7));
        send(lit(16'd9));
        drain(1'b0);

        // Run of 3 overlapped with the following literal.
        send(run(3));
        send(lit(16'h00A1));
        drain(1'b0);

        // Two maximal runs back to back.
        send(run(15));
        send(run(15));
        drain(1'b0);

        // Stalls during a run.
        send(run(4));
        drain(1'b1);

        // Literal zero is an ordinary word.
        send(lit(16'd0));
        drain(1'b0);

        // Zero-count run raises the sticky error.
        send(run(0));
        send(lit(16'd3));
        drain(1'b0);
        send(lit(16'h1234));
        drain(1'b0);

        // Asynchronous reset in the middle of a run of 10.
        send(run(10));
        cycle();
        cycle();
        #2;
        reset = 1'b0;
        #1;
        check("arst_o_v", 32'(o_v), 32'd0);
        check("arst_stateo", 32'(stateo), 32'd0);
        check("arst_i_b", 32'(i_b), 32'd0);
        check("arst_o_d", 32'(o_d), 32'd0);
        check("arst_err", 32'(err), 32'd0);
        q.delete();
        m_err = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        send(lit(16'd4));
        drain(1'b0);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            i_v = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 9) < 4) i_d = lit(DW'($urandom));
            else i_d = run($urandom_range(0, 15));
            o_b = ($urandom_range(0, 9) < 3);
            cycle();
        end
        i_v = 1'b0;
        drain(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/zle_dec.md
# zle_dec

Zero run-length decoder: the receive end of the ZLE token stream. It consumes encoded tokens, each either a literal or a zero-run count, and expands them into a flat stream of data words with the runs of zeros restored. It sits downstream of the ZLE encoder and uses the same valid/back-pressure stream handshake on both sides. Sustained throughput is one output word per cycle.

## Interface
- DW, 16: decoded data word width.
- CW, 4: run-count field width; MAXRUN = 2^CW − 1 (15).
- clock  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-low.
- i_v  in  1  input token valid.
- i_d  in  DW+1  token. Bit DW is the flag: 0 = literal in i_d[DW-1:0]; 1 = zero-run token with count in i_d[CW-1:0]. Bits i_d[DW-1:CW] are ignored on run tokens.
- i_b  out  1  input back-pressure. A token transfers when i_v=1 and i_b=0.
- o_v  out  1  output valid.
- o_d  out  DW  decoded word.
- o_b  in  1  output back-pressure. A word transfers when o_v=1 and o_b=0.
- err  out  1  sticky flag; set on a zero-count run token, cleared only by reset.
- stateo  out  2  current FSM state, for debug and datapath observation.

## Operation
- Registers:
  - state
  - tok (DW-bit literal hold)
  - rem (CW-bit remaining zero count)
  - err
- States: S_FETCH=0, S_LIT=1, S_RUN=2. Encoding 3 is illegal; it forces state to S_FETCH on the next clock.
- Token load (shared by all accept points):
  - Literal: tok ← i_d[DW-1:0], go to S_LIT.
  - Run with count c ≥ 1: rem ← c, go to S_RUN.
  - Run with c = 0: consume the token, produce no output, set err, go to or stay in S_FETCH.
- S_FETCH:
  - o_v=0, i_b=0.
  - On i_v, apply the token load.
- S_LIT:
  - o_v=1, o_d=tok, i_b=o_b.
  - On !o_b, the literal transfers.
  - If i_v is also high, the next token is loaded in the same cycle. Otherwise go to S_FETCH.
- S_RUN:
  - o_v=1, o_d=0.
  - If rem>1: i_b=1. On !o_b, rem ← rem−1.
  - If rem==1: i_b=o_b. On !o_b, the last zero transfers and the next token is loaded as in S_LIT. With no token available, go to S_FETCH.
- Literal value 0 is legal: it is emitted as a single zero word with no error.
- Arithmetic: rem decrement is CW-bit unsigned. rem is never 0 in S_RUN, so there is no wrap.
- The block emits no EOS or flush; token boundaries are invisible at the output.

## Timing
- Reset (async assert, synchronous use after release):
  - state=S_FETCH, tok=0, rem=0, err=0.
  - Therefore o_v=0, o_d=0, i_b=0, stateo=0.
- Latency: a token accepted at edge N produces its first output word valid in cycle N+1.
- o_v and o_d depend only on registers.
- i_b has a combinational path from o_b (in S_LIT, and in S_RUN with rem==1). Upstream must not make i_v depend combinationally on i_b.
- Back-to-back operation: with i_v and !o_b held high, the output carries one word every cycle. There are no bubbles between tokens.
- A run token of count c occupies the output for exactly c transferred cycles. Stall cycles (o_b=1) freeze rem, tok and state.
- Reset asserted mid-run discards tok and rem. No partial run is resumed.
- i_d is sampled only on a transfer edge. It is don't-care otherwise.

## Structure
- Shared package zle_pkg, also used by the encoder:
  - state encodings;
  - flag bit position (DW);
  - CW default;
  - MAXRUN;
  - token-field accessor constants.
- One sub-module is natural: zle_dec_fsm, holding state, the next-state/handshake logic and stateo. It takes flags in from the datapath: tok_is_run, cnt_eq_0, rem_eq_1.
- The top-level zle_dec holds tok, rem, err, the o_d mux and the flag decode.

## Test plan
- Literals 5, 7, 9 back-to-back, o_b=0 → o_d=5, 7, 9 on three consecutive cycles starting 1 cycle after the first accept; i_b never high.
- Run token count 3, then literal 0x00A1 → o_d=0, 0, 0, 0x00A1. The literal is accepted on the cycle the third zero transfers; i_b is high for the first two zero cycles.
- Run count 15 followed by run count 15 → 30 zeros with no gap; stateo=2 throughout.
- o_b toggling 1,0,1,0 during a run of 4 → exactly 4 zero transfers; rem decrements only on o_b=0 cycles.
- Run token count 0, then literal 3 → err=1 one cycle after the accept; next output is 3; err stays 1.
- Reset pulsed low after 2 of 10 zeros → o_v=0 and stateo=0 immediately (asynchronous). After release, a literal 4 is decoded normally with no leftover zeros.
